// File: rtl/neuro_pkg.sv
// -----------------------------------------------------------------------------
// neuro_pkg
//   Fixed-point constants and helpers shared by the skin-classifier neuron
//   stages (weighted-sum MAC and the threshold comparator downstream).
//
//   DATA_W   : operand/result width, two's complement
//   FRAC_W   : fractional bits of every operand and result
//   data_t   : signed DATA_W sample type
//   SAT_MAX  : largest representable data_t
//   SAT_MIN  : smallest representable data_t
//   clog2()  : ceiling log2, usable in constant expressions
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

package neuro_pkg;

  localparam int DATA_W = 16;
  localparam int FRAC_W = 8;

  typedef logic signed [DATA_W-1:0] data_t;

  localparam data_t SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam data_t SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  // clog2(1) = 0, clog2(3) = 2, clog2(4) = 2
  function automatic int clog2(input int value);
    int res;
    int rem;
    res = 0;
    rem = value - 1;
    while (rem > 0) begin
      res = res + 1;
      rem = rem >>> 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/neuron_mac_sat.sv
// -----------------------------------------------------------------------------
// neuron_mac_sat
//   Combinational rescale of the full-precision accumulator back to DATA_W:
//   arithmetic right shift by FRAC_W, then clamp to the signed DATA_W range.
//   The parent registers the result.
//
//   Build option NEURON_MAC_ROUND_EN: when defined, 2^(FRAC_W-1) is added
//   before the shift (round half toward +inf); otherwise the shift truncates
//   toward -inf.
//
//   Ports
//     acc : signed ACC_W accumulator (Q2F alignment)
//     sat : signed DATA_W saturated result (QF alignment)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module neuron_mac_sat #(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8,
  parameter int ACC_W  = 36
) (
  input  logic signed [ACC_W-1:0]  acc,
  output logic signed [DATA_W-1:0] sat
);

  localparam logic signed [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic signed [ACC_W-1:0]  MAX_EXT = ACC_W'(SAT_MAX);
  localparam logic signed [ACC_W-1:0]  MIN_EXT = ACC_W'(SAT_MIN);

`ifdef NEURON_MAC_ROUND_EN
  localparam logic signed [ACC_W-1:0] HALF = ACC_W'(1) << (FRAC_W - 1);
`endif

  logic signed [ACC_W-1:0] rnd;
  logic signed [ACC_W-1:0] shf;

  // NOTE: every output of a combinational block gets a value on every path
  // (default first, then overrides) so no latch is inferred.
  always_comb begin
`ifdef NEURON_MAC_ROUND_EN
    rnd = acc + HALF;
`else
    rnd = acc;
`endif
    shf = rnd >>> FRAC_W;
    sat = shf[DATA_W-1:0];
    if (shf > MAX_EXT) begin
      sat = SAT_MAX;
    end else if (shf < MIN_EXT) begin
      sat = SAT_MIN;
    end
  end

endmodule

// File: rtl/neuron_mac.sv
// -----------------------------------------------------------------------------
// neuron_mac
//   Weighted-sum stage of the skin-classifier neuron. Accumulates
//   bias + sum(data*weight) over N_IN elements at full precision, rescales to
//   DATA_W with saturation and emits one result with a single-cycle valid
//   pulse. Three register stages: A (multiply), B (accumulate), C (rescale).
//
//   Build option NEURON_MAC_ROUND_EN selects round-half-up instead of
//   truncation in stage C (see neuron_mac_sat); timing is unchanged.
//
//   Ports
//     clk       : clock, rising edge
//     rst       : synchronous active-high reset
//     in_valid  : element present (always accepted, no backpressure)
//     in_data   : signed sample
//     in_weight : signed weight for in_data
//     in_bias   : signed bias, used only with the first element of a vector
//     out_valid : one-cycle result pulse
//     out_data  : saturated weighted sum, held between pulses
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module neuron_mac #(
  parameter int DATA_W = neuro_pkg::DATA_W,
  parameter int FRAC_W = neuro_pkg::FRAC_W,
  parameter int N_IN   = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic signed [DATA_W-1:0] in_weight,
  input  logic signed [DATA_W-1:0] in_bias,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] out_data
);

  localparam int PROD_W = 2 * DATA_W;
  // Two guard bits above the product sum also cover the aligned bias.
  localparam int ACC_W  = PROD_W + neuro_pkg::clog2(N_IN) + 2;
  localparam int CNT_W  = (N_IN > 1) ? neuro_pkg::clog2(N_IN) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_IN - 1);

  // Element position within the current vector
  logic [CNT_W-1:0] cnt;
  logic             first;
  logic             last;

  assign first = (cnt == '0);
  assign last  = (cnt == LAST_CNT);

  // NOTE: all clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (in_valid) begin
      cnt <= last ? '0 : cnt + 1'b1;
    end
  end

  // Stage A: product and bias aligned to the product's 2*FRAC_W binary point
  logic                     valid_a;
  logic                     first_a;
  logic                     last_a;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  bias_a;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_a <= 1'b0;
      first_a <= 1'b0;
      last_a  <= 1'b0;
      prod    <= '0;
      bias_a  <= '0;
    end else begin
      valid_a <= in_valid;
      if (in_valid) begin
        prod    <= PROD_W'(in_data) * PROD_W'(in_weight);
        bias_a  <= ACC_W'(in_bias) <<< FRAC_W;
        first_a <= first;
        last_a  <= last;
      end
    end
  end

  // Stage B: running sum, restarted from the bias on the first element
  logic                    done_b;
  logic signed [ACC_W-1:0] acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      done_b <= 1'b0;
      acc    <= '0;
    end else begin
      done_b <= valid_a & last_a;
      if (valid_a) begin
        acc <= (first_a ? bias_a : acc) + ACC_W'(prod);
      end
    end
  end

  // Stage C: rescale/saturate and publish
  logic signed [DATA_W-1:0] sat_data;

  neuron_mac_sat #(
    .DATA_W (DATA_W),
    .FRAC_W (FRAC_W),
    .ACC_W  (ACC_W)
  ) u_sat (
    .acc (acc),
    .sat (sat_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= done_b;
      if (done_b) begin
        out_data <= sat_data;
      end
    end
  end

endmodule
